hangman_round_ctrl: RTL

Sequences one Hangman round on top of the hex letter displays.
- Picks a word from an internal 5-entry word ROM.
- Accepts guesses one at a time on a submit strobe, scores each guess, reveals letters and counts wrong guesses.
- Drives win/lose status and valid/invalid feedback pulses.
- Sits between the board switches/keys and the hangman_hex display decoders; its letter_display outputs feed those decoders directly.

---
 rtl/hangman_round_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/hangman_round_ctrl.sv
// Hangman round sequencer: word ROM, guess scoring, reveal mask, wrong count and feedback pulses.
// Optional macro HANGMAN_FIRST_LETTER_EN pre-reveals position 1 at the start of every round.
module hangman_round_ctrl #(
   parameter int MAX_WRONG = 4,
   parameter int FB_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       submit,
   input  logic [5:0] guess,
   output logic [5:0] letter_display1,
   output logic [5:0] letter_display2,
   output logic [5:0] letter_display3,
   output logic [5:0] letter_display4,
   output logic [2:0] wrong_guesses,
   output logic       valid,
   output logic       invalid,
   output logic [1:0] game_status
);

   localparam int FBW = $clog2(FB_CYCLES + 1);
   localparam logic [FBW-1:0] FB_LOAD = FBW'(FB_CYCLES);
   localparam logic [FBW-1:0] FB_ONE  = FBW'(1);
   localparam logic [2:0]     MAX_W   = 3'(MAX_WRONG);
`ifdef HANGMAN_FIRST_LETTER_EN
   localparam logic [3:0]     LOAD_MASK = 4'b0001;
`else
   localparam logic [3:0]     LOAD_MASK = 4'b0000;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_WAIT     = 3'd2,
      S_EVAL     = 3'd3,
      S_FEEDBACK = 3'd4,
      S_WIN      = 3'd5,
      S_LOSE     = 3'd6
   } state_t;

   // Word ROM; position 1 is the most significant code of each word.
   function automatic logic [5:0] rom_code(input logic [2:0] idx, input logic [1:0] pos);
      logic [23:0] w;
      case (idx)
         3'd0:    w = {6'h1C, 6'h1D, 6'h0A, 6'h22};
         3'd1:    w = {6'h0D, 6'h0A, 6'h1B, 6'h17};
         3'd2:    w = {6'h15, 6'h0E, 6'h0A, 6'h0F};
         3'd3:    w = {6'h11, 6'h0E, 6'h0A, 6'h0D};
         3'd4:    w = {6'h15, 6'h12, 6'h0F, 6'h0E};
         default: w = 24'd0;
      endcase
      case (pos)
         2'd0:    rom_code = w[23:18];
         2'd1:    rom_code = w[17:12];
         2'd2:    rom_code = w[11:6];
         default: rom_code = w[5:0];
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [2:0]      rnd_q, rnd_d, word_q, word_d, wrong_q, wrong_d;
   logic [2:0]      start_sync_q, start_sync_d, submit_sync_q, submit_sync_d;
   logic [5:0]      guess_q, guess_d;
   logic [3:0]      mask_q, mask_d;
   logic [FBW-1:0]  fb_cnt_q, fb_cnt_d;
   logic            valid_q, valid_d, invalid_q, invalid_d;
   logic [1:0]      status_q, status_d;
   logic [3:0][5:0] disp_q, disp_d, code_s;
   logic [3:0]      match_s, hit_s;
   logic            start_edge_s, submit_edge_s, legal_s;

   assign start_edge_s  = start_sync_q[1] & ~start_sync_q[2];
   assign submit_edge_s = submit_sync_q[1] & ~submit_sync_q[2];
   assign legal_s       = (guess_q >= 6'h0A) && (guess_q <= 6'h22);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         code_s[i]  = rom_code(word_q, 2'(i));
         hit_s[i]   = (code_s[i] == guess_q);
         match_s[i] = hit_s[i] & ~mask_q[i];
      end
   end

   always_comb begin
      state_d       = state_q;
      rnd_d         = (rnd_q == 3'd4) ? 3'd0 : rnd_q + 3'd1;
      start_sync_d  = {start_sync_q[1:0], start};
      submit_sync_d = {submit_sync_q[1:0], submit};
      word_d        = word_q;
      guess_d       = guess_q;
      mask_d        = mask_q;
      wrong_d       = wrong_q;
      fb_cnt_d      = fb_cnt_q;
      valid_d       = valid_q;
      invalid_d     = invalid_q;
      disp_d        = disp_q;
      status_d      = 2'd0;

      // Feedback timeout runs in every state so WIN/LOSE pulses also expire.
      if (fb_cnt_q != '0) begin
         fb_cnt_d = fb_cnt_q - FB_ONE;
         if (fb_cnt_q == FB_ONE) begin
            valid_d   = 1'b0;
            invalid_d = 1'b0;
         end else begin
            valid_d   = valid_q;
         end
      end else begin
         fb_cnt_d = fb_cnt_q;
      end

      case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (start_edge_s) begin
               word_d  = rnd_q;
               state_d = S_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         S_LOAD: begin
            mask_d  = LOAD_MASK;
            wrong_d = 3'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (submit_edge_s) begin
               guess_d = guess;
               state_d = S_EVAL;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_EVAL: begin
            fb_cnt_d  = FB_LOAD;
            valid_d   = 1'b0;
            invalid_d = 1'b0;
            if (match_s != 4'b0000) begin
               mask_d  = mask_q | match_s;
               valid_d = 1'b1;
            end else if (legal_s && (hit_s == 4'b0000) && (wrong_q < MAX_W)) begin
               wrong_d   = wrong_q + 3'd1;
               invalid_d = 1'b1;
            end else begin
               mask_d = mask_q;
            end
            if (mask_d == 4'b1111) begin
               state_d = S_WIN;
            end else if (wrong_d == MAX_W) begin
               state_d = S_LOSE;
            end else begin
               state_d = S_FEEDBACK;
            end
         end
         S_FEEDBACK: begin
            if (fb_cnt_q <= FB_ONE) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_FEEDBACK;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Displays and status follow the next state so every output is a flop.
      for (int i = 0; i < 4; i++) begin
         if ((state_d == S_WIN) || (state_d == S_LOSE)) begin
            disp_d[i] = rom_code(word_d, 2'(i));
         end else if ((state_d == S_LOAD) || !mask_d[i]) begin
            disp_d[i] = 6'h00;
         end else begin
            disp_d[i] = rom_code(word_d, 2'(i));
         end
      end
      if (state_d == S_LOSE) begin
         status_d = 2'd1;
      end else if (state_d == S_WIN) begin
         status_d = 2'd2;
      end else begin
         status_d = 2'd0;
      end
   end

   // State and output registers; resetn is active high despite its name.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q       <= S_IDLE;
         rnd_q         <= 3'd0;
         start_sync_q  <= 3'd0;
         submit_sync_q <= 3'd0;
         word_q        <= 3'd0;
         guess_q       <= 6'h00;
         mask_q        <= 4'b0000;
         wrong_q       <= 3'd0;
         fb_cnt_q      <= '0;
         valid_q       <= 1'b0;
         invalid_q     <= 1'b0;
         status_q      <= 2'd0;
         disp_q        <= '0;
      end else begin
         state_q       <= state_d;
         rnd_q         <= rnd_d;
         start_sync_q  <= start_sync_d;
         submit_sync_q <= submit_sync_d;
         word_q        <= word_d;
         guess_q       <= guess_d;
         mask_q        <= mask_d;
         wrong_q       <= wrong_d;
         fb_cnt_q      <= fb_cnt_d;
         valid_q       <= valid_d;
         invalid_q     <= invalid_d;
         status_q      <= status_d;
         disp_q        <= disp_d;
      end
   end

   assign letter_display1 = disp_q[0];
   assign letter_display2 = disp_q[1];
   assign letter_display3 = disp_q[2];
   assign letter_display4 = disp_q[3];
   assign wrong_guesses   = wrong_q;
   assign valid           = valid_q;
   assign invalid         = invalid_q;
   assign game_status     = status_q;

endmodule
